// File: rtl/piso_shift_tx_if.sv
// Load handshake and serial stream of piso_shift_tx. The master drives the word and enable,
// and the slave (the transmitter) drives status and the serial bit.
interface piso_shift_tx_if #(
    parameter int unsigned WIDTH = 4
);
    logic             en;
    logic [WIDTH-1:0] d;
    logic             load_valid;
    logic             load_ready;
    logic             serial_out;
    logic             serial_valid;
    logic             busy;
    logic             done;

    modport master (
        output en, d, load_valid,
        input  load_ready, serial_out, serial_valid, busy, done
    );

    modport slave (
        input  en, d, load_valid,
        output load_ready, serial_out, serial_valid, busy, done
    );
endinterface

// File: rtl/piso_shift_tx.sv
// Parallel-in, serial-out transmitter. It accepts a word on a load handshake, shifts out one
// bit per enabled clock, and pulses done once after the last bit.
module piso_shift_tx #(
    parameter int unsigned WIDTH     = 4,
    parameter bit          MSB_FIRST = 1'b1
) (
    input logic            i_clk,
    input logic            i_rst,
    piso_shift_tx_if.slave bus
);
    localparam int unsigned CntW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StDone  = 2'd2
    } state_e;

    state_e           r_state;
    state_e           w_state_next;
    logic [WIDTH-1:0] r_sh;
    logic [WIDTH-1:0] w_sh_next;
    logic [CntW-1:0]  r_cnt;
    logic [CntW-1:0]  w_cnt_next;
    logic             w_tx_bit;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= StIdle;
            r_sh    <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_sh    <= w_sh_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_sh_next    = r_sh;
        w_cnt_next   = r_cnt;
        unique case (r_state)
            StIdle: begin
                if (bus.load_valid) begin
                    w_sh_next    = bus.d;
                    w_cnt_next   = CntW'(WIDTH);
                    w_state_next = StShift;
                end
            end
            StShift: begin
                if (bus.en) begin
                    w_sh_next  = MSB_FIRST ? {r_sh[WIDTH-2:0], 1'b0} : {1'b0, r_sh[WIDTH-1:1]};
                    w_cnt_next = r_cnt - CntW'(1);
                    // Leaving at cnt==1 keeps the counter from ever wrapping.
                    if (r_cnt == CntW'(1)) begin
                        w_state_next = StDone;
                    end
                end
            end
            StDone: begin
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    assign w_tx_bit         = MSB_FIRST ? r_sh[WIDTH-1] : r_sh[0];
    assign bus.load_ready   = (r_state == StIdle);
    assign bus.serial_valid = (r_state == StShift);
    assign bus.serial_out   = (r_state == StShift) & w_tx_bit;
    assign bus.busy         = (r_state == StShift) | (r_state == StDone);
    assign bus.done         = (r_state == StDone);
endmodule

// File: tb/tb_piso_shift_tx.sv
// Bench for piso_shift_tx: a 4-bit MSB-first and an 8-bit LSB-first instance, each with a SIPO
// loopback, checked every cycle against a word-level model.
module tb_piso_shift_tx;
    localparam int unsigned WA = 4;
    localparam int unsigned WB = 8;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    piso_shift_tx_if #(.WIDTH(WA)) bus_a ();
    piso_shift_tx_if #(.WIDTH(WB)) bus_b ();

    piso_shift_tx #(.WIDTH(WA), .MSB_FIRST(1'b1)) u_a (.i_clk(clk), .i_rst(rst), .bus(bus_a));
    piso_shift_tx #(.WIDTH(WB), .MSB_FIRST(1'b0)) u_b (.i_clk(clk), .i_rst(rst), .bus(bus_b));

    // Receivers on the same clk/rst/en; MSB-first fills from the right, LSB-first from the left.
    logic [WA-1:0] sipo_a;
    logic [WB-1:0] sipo_b;
    always_ff @(posedge clk) begin
        if (rst) begin
            sipo_a <= '0;
            sipo_b <= '0;
        end else begin
            if (bus_a.en) sipo_a <= {sipo_a[WA-2:0], bus_a.serial_out};
            if (bus_b.en) sipo_b <= {bus_b.serial_out, sipo_b[WB-1:1]};
        end
    end

    // Word-level model: phase 0 idle, 1 sending, 2 done; sent = enabled edges since load.
    int          m_phase [2];
    int          m_sent  [2];
    logic [31:0] m_word  [2];
    int          m_width [2];
    bit          m_msb   [2];

    task automatic model_update(input int i, input bit r, input bit lv, input logic [31:0] d,
                                input bit e);
        if (r) begin
            m_phase[i] = 0;
            m_sent[i]  = 0;
        end else begin
            case (m_phase[i])
                0: if (lv) begin
                    m_word[i]  = d;
                    m_sent[i]  = 0;
                    m_phase[i] = 1;
                end
                1: if (e) begin
                    m_sent[i] = m_sent[i] + 1;
                    if (m_sent[i] == m_width[i]) m_phase[i] = 2;
                end
                default: m_phase[i] = 0;
            endcase
        end
    endtask

    function automatic logic exp_sout(input int i);
        int idx;
        if (m_phase[i] != 1) return 1'b0;
        idx = m_msb[i] ? (m_width[i] - 1 - m_sent[i]) : m_sent[i];
        return m_word[i][idx];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("a_load_ready",   32'(bus_a.load_ready),   32'(m_phase[0] == 0));
        chk("a_serial_valid", 32'(bus_a.serial_valid), 32'(m_phase[0] == 1));
        chk("a_serial_out",   32'(bus_a.serial_out),   32'(exp_sout(0)));
        chk("a_busy",         32'(bus_a.busy),         32'(m_phase[0] != 0));
        chk("a_done",         32'(bus_a.done),         32'(m_phase[0] == 2));
        chk("b_load_ready",   32'(bus_b.load_ready),   32'(m_phase[1] == 0));
        chk("b_serial_valid", 32'(bus_b.serial_valid), 32'(m_phase[1] == 1));
        chk("b_serial_out",   32'(bus_b.serial_out),   32'(exp_sout(1)));
        chk("b_busy",         32'(bus_b.busy),         32'(m_phase[1] != 0));
        chk("b_done",         32'(bus_b.done),         32'(m_phase[1] == 2));
        if (m_phase[0] == 2) chk("a_loopback", 32'(sipo_a), m_word[0]);
        if (m_phase[1] == 2) chk("b_loopback", 32'(sipo_b), m_word[1]);
    endtask

    // One clock: drive inputs, advance the model for this edge, then sample after the edge.
    task automatic step(input bit r, input bit lva, input logic [WA-1:0] da, input bit lvb,
                        input logic [WB-1:0] db, input bit e);
        rst              = r;
        bus_a.load_valid = lva;
        bus_a.d          = da;
        bus_a.en         = e;
        bus_b.load_valid = lvb;
        bus_b.d          = db;
        bus_b.en         = e;
        model_update(0, r, lva, 32'(da), e);
        model_update(1, r, lvb, 32'(db), e);
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        logic [WA-1:0] ra;
        logic [WB-1:0] rb;
        bit            gap_en [7];
        m_width[0] = WA; m_msb[0] = 1'b1; m_phase[0] = 0; m_sent[0] = 0; m_word[0] = '0;
        m_width[1] = WB; m_msb[1] = 1'b0; m_phase[1] = 0; m_sent[1] = 0; m_word[1] = '0;
        gap_en = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

        // Reset overrides load_valid and en.
        step(1'b1, 1'b1, 4'hF, 1'b1, 8'hFF, 1'b1);
        step(1'b1, 1'b1, 4'hF, 1'b1, 8'hFF, 1'b1);

        // Basic MSB-first transfer of 1011.
        step(1'b0, 1'b1, 4'b1011, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 4'h0, 1'b0, 8'h00, 1'b1);

        // Gapped enable with 0110.
        step(1'b0, 1'b1, 4'b0110, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 4'h0, 1'b0, 8'h00, gap_en[i]);
        for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 4'h0, 1'b0, 8'h00, 1'b0);

        // Back-pressure: load_valid held with D changing; only first-IDLE loads are taken.
        for (int i = 0; i < 2 * (WA + 2); i++) begin
            ra = 4'($urandom);
            step(1'b0, 1'b1, ra, 1'b0, 8'h00, 1'b1);
        end
        for (int i = 0; i < WA + 2; i++) step(1'b0, 1'b0, 4'h0, 1'b0, 8'h00, 1'b1);

        // Reset mid-word, then a clean 1001.
        step(1'b0, 1'b1, 4'b1111, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b0, 4'h0, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b0, 4'h0, 1'b0, 8'h00, 1'b1);
        step(1'b1, 1'b0, 4'h0, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b1, 4'b1001, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 4'h0, 1'b0, 8'h00, 1'b1);

        // Wide LSB-first instance with A5.
        step(1'b0, 1'b0, 4'h0, 1'b1, 8'hA5, 1'b1);
        for (int i = 0; i < WB + 2; i++) step(1'b0, 1'b0, 4'h0, 1'b0, 8'h00, 1'b1);

        // Randomised traffic on both instances with sparse resets.
        for (int i = 0; i < 400; i++) begin
            ra = 4'($urandom);
            rb = 8'($urandom);
            step(($urandom_range(0, 59) == 0), ($urandom_range(0, 2) != 0), ra,
                 ($urandom_range(0, 2) != 0), rb, ($urandom_range(0, 9) < 7));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/piso_shift_tx.md
Name: piso_shift_tx

Overview:
- Parallel-in, serial-out transmitter; the sending end of the team's serial-in, parallel-out D-flip-flop shift register.
- Accepts a WIDTH-bit word through a valid/ready load handshake.
- Shifts the word out one bit per enabled clock.
- Flags completion with a one-cycle done pulse.
- Default MSB-first order lets a WIDTH-bit SIPO on the same clk/en rebuild the word exactly after WIDTH enabled edges.

Parameters:
WIDTH, 4, word width in bits; legal range is 2 to 32.
MSB_FIRST, 1, 1 = transmit D[WIDTH-1] first; 0 = transmit D[0] first.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  synchronous reset, active-high; highest priority.
en  input  1  shift enable; advances one bit per rising edge while shifting.
D  input  WIDTH  parallel word to transmit; sampled only on an accepted load.
load_valid  input  1  a word is offered on D.
load_ready  output  1  block can accept a word; equals (state == IDLE).
serial_out  output  1  current serial bit; 0 whenever not in SHIFT.
serial_valid  output  1  serial_out holds a data bit; equals (state == SHIFT).
busy  output  1  high in SHIFT and DONE.
done  output  1  one-cycle pulse after the last bit has been shifted.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high. Nothing is asynchronous.
- Reset, applied on an edge with rst=1:
  - state=IDLE; shift register=0; bit counter=0.
  - Outputs after that edge: load_ready=1, serial_out=0, serial_valid=0, busy=0, done=0.
  - rst overrides load_valid and en on the same edge.
- Storage:
  - WIDTH-bit shift register sh.
  - Counter cnt, width clog2(WIDTH+1), counting remaining bits.
- State IDLE:
  - load_ready=1.
  - Edge with load_valid=1: sh<=D, cnt<=WIDTH, go to SHIFT. This is an accepted load.
  - en is ignored in IDLE.
- State SHIFT:
  - serial_valid=1.
  - serial_out = sh[WIDTH-1] when MSB_FIRST=1, sh[0] when MSB_FIRST=0; combinational from sh.
  - Edge with en=1:
    - MSB_FIRST=1: sh shifts left with 0 fill.
    - MSB_FIRST=0: sh shifts right with 0 fill.
    - cnt<=cnt-1.
    - If cnt was 1, go to DONE.
  - en=0: sh, cnt and state hold. Gaps of any length are legal.
  - load_valid is ignored (load_ready=0); D is not sampled.
- State DONE:
  - done=1 and busy=1 for exactly one cycle, then unconditionally IDLE.
  - load_valid in DONE is ignored.
  - A new word is accepted at the earliest on the first IDLE cycle.
  - Maximum throughput is one word per WIDTH+2 cycles with en held high.
- Latency, with the load accepted at edge L:
  - First bit is valid in the cycle after L.
  - Bit k (0-based) is presented until the k-th enabled edge after L.
  - done is high in the cycle after the WIDTH-th enabled edge.
- Reset mid-operation (SHIFT or DONE):
  - Word is abandoned; no done pulse.
  - Outputs take reset values after the rst edge.
- No wrap-around: cnt never underflows, since SHIFT exits at cnt==1 with en=1.
- Encoding:
  - 3-state FSM: IDLE, SHIFT, DONE.
  - Outputs are decoded from state and sh only; no output depends combinationally on inputs.

Test Plan:
1. Reset: hold rst=1 for 2 cycles with load_valid=1 and en=1 -> after reset load_ready=1, serial_valid=0, serial_out=0, done=0, busy=0.
2. Basic MSB-first transfer:
   - Stimulus: WIDTH=4, D=4'b1011 with load_valid for 1 cycle, en held at 1.
   - Response: serial_out=1,0,1,1 in SHIFT cycles 1-4; done=1 in cycle 5; load_ready=1 in cycle 6.
   - Loopback: a 4-bit SIPO driven with the same clk/rst/en and d=serial_out reads Q=4'b1011 when done=1.
3. Gapped enable:
   - Stimulus: D=4'b0110, en pattern 1,0,0,1,0,1,1.
   - Response: serial_out stays at each bit while en=0; bits out are 0,1,1,0; done arrives one cycle after the 4th en=1 edge; cnt never skips.
4. Back-pressure:
   - Stimulus: load_valid held at 1 with D changing every cycle during SHIFT and DONE.
   - Response: only the first word is transmitted. The next load is accepted on the first IDLE cycle, with D sampled at that edge.
5. Reset mid-word: D=4'b1111, assert rst after 2 enabled shifts -> serial_valid=0 and busy=0 next cycle; done is never pulsed; the next load of 4'b1001 transmits 1,0,0,1.
6. Parameters: WIDTH=8, MSB_FIRST=0, D=8'hA5 with en=1 -> serial_out=1,0,1,0,0,1,0,1 (LSB first); done in cycle 9.
